perceptron_driver: RTL and testbench
====================================

PERCEPTRON_DRIVER -- requirements
Module: perceptron_driver

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning sample-buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter CW, default $clog2(DEPTH)+1, meaning sample-count width.
REQ-003 SHALL have ports, as listed below; one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  write one sample into the buffer
- wr_x1, wr_x2  in  6 each  sample features
- wr_label  in  1  sample target (1 = positive class)
- clr  in  1  empty the buffer
- w0_init, w1_init, w2_init, n_init  in  6 each  initial weights and learning rate, sampled on start
- train  in  1  1 = training pass; 0 = classify only
- epochs  in  4  number of replays of the buffer (0 is treated as 1)
- start  in  1  begin run
- abort  in  1  return to IDLE
- sync, done, classification  in  1 each  from the perceptron
- go, update, correct  out  1 each  to the perceptron
- in_val  out  6  data word to the perceptron
- busy  out  1  run in progress
- finished  out  1  one-cycle pulse at run end
- class_valid  out  1  one-cycle pulse per classified sample
- class_out  out  1  classification captured with class_valid
- class_idx  out  CW-1  sample index for class_out
- err_count  out  CW  mismatches in the current/last epoch
- sample_count  out  CW  buffered samples

Function
REQ-004 SHALL have states IDLE, LD_W0, LD_W1, LD_W2, LD_N, LD_X1, LD_X2, WAIT_DONE, NEXT.
REQ-005 IDLE: wr_en with sample_count<DEPTH SHALL store {x1,x2,label} at index sample_count and increment it; writes when full, or outside IDLE, SHALL be ignored.
REQ-006 IDLE: clr SHALL zero sample_count; clr has priority over a simultaneous wr_en.
REQ-007 IDLE: start with sample_count>0 SHALL latch the *_init words, train and epochs, clear err_count, and go to LD_W0; start with an empty buffer SHALL be ignored.
REQ-008 LD_W0/LD_W1/LD_W2/LD_N/LD_X1: go=1, in_val = w0/w1/w2/n/x1[idx]; the state SHALL advance on the cycle sync=1 and hold otherwise.
REQ-009 LD_X2: go=1, in_val=x2[idx] for exactly one cycle, with no sync wait, then WAIT_DONE.
REQ-010 go SHALL be 0 in IDLE, WAIT_DONE and NEXT; in_val SHALL be 0 when go=0.
REQ-011 update SHALL equal the latched train and correct SHALL equal label[idx] from LD_X1 through WAIT_DONE, held stable; both SHALL be 0 otherwise.
REQ-012 WAIT_DONE: on done=1, SHALL pulse class_valid with class_out=classification and class_idx=idx, increment err_count if classification!=label[idx] (saturating), and go to NEXT.
REQ-013 NEXT: if idx<sample_count-1, increment idx and go to LD_X1; else if epoch<epochs-1, set idx=0, increment epoch, clear err_count, and go to LD_X1; else pulse finished and go to IDLE.
REQ-014 Weights and n SHALL be sent once per run; later samples restart at LD_X1.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 abort in any non-IDLE state SHALL go to IDLE next cycle with go=0 and no finished pulse; buffer contents and err_count SHALL be kept.
REQ-017 Counters SHALL not wrap: err_count saturates at 2^CW-1; idx is bounded by sample_count.

Reset
REQ-018 reset SHALL force IDLE, zero sample_count, idx, epoch and err_count, and drive every output to 0; buffer storage need not be cleared.
REQ-019 reset SHALL take priority over abort, start, clr and wr_en.

Structure
REQ-020 The state enum and the sample record struct {x1,x2,label} SHALL live in package perceptron_pkg, shared with the perceptron.
REQ-021 The buffer SHALL be a separate sub-module sample_buf (write port plus one combinational read port); the FSM and counters SHALL live in perceptron_driver.

Verification
REQ-022 Write 2 samples, start with train=0, epochs=1, sync tied to go, done one cycle after WAIT_DONE entry -> in_val sequence w0,w1,w2,n,x1a,x2a,x1b,x2b; two class_valid pulses; finished once.
REQ-023 sync held 0 for 5 cycles in LD_W1 -> go=1 and in_val=w1 held all 5 cycles; advance on the first sync=1.
REQ-024 Labels {1,0}, classifications {0,0}, epochs=2 -> err_count=1 after each epoch; 4 class_valid pulses; weights sent only once.
REQ-025 5 writes with DEPTH=4 -> sample_count=4, fifth sample dropped; clr plus wr_en in the same cycle -> sample_count=0.
REQ-026 abort in WAIT_DONE -> IDLE next cycle, busy=0, no finished pulse; reset mid-run -> all outputs 0 and sample_count=0.
REQ-027 start with an empty buffer -> remains IDLE with busy=0.

Source files
------------

// File: rtl/perceptron_pkg.sv
// Shared types for the perceptron driver and the perceptron itself.
// Holds the driver state encoding and the buffered sample record.
package perceptron_pkg;

    localparam int XW = 6;
    localparam int EW = 4;

    typedef enum logic [3:0] {
        IDLE,
        LD_W0,
        LD_W1,
        LD_W2,
        LD_N,
        LD_X1,
        LD_X2,
        WAIT_DONE,
        NEXT
    } state_t;

    typedef struct packed {
        logic [XW-1:0] x1;
        logic [XW-1:0] x2;
        logic          label;
    } sample_t;

endpackage

// File: rtl/sample_buf.sv
// Sample storage: one synchronous write port, one combinational read port.
// Contents are not reset; the driver's sample count says what is valid.
module sample_buf
    import perceptron_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  sample_t       wdata,
    input  logic [AW-1:0] raddr,
    output sample_t       rdata
);

    sample_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/perceptron_driver.sv
// Replays buffered samples into a perceptron: weights and rate once,
// then x1/x2 per sample per epoch, collecting classifications.
module perceptron_driver
    import perceptron_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [XW-1:0] wr_x1,
    input  logic [XW-1:0] wr_x2,
    input  logic          wr_label,
    input  logic          clr,
    input  logic [XW-1:0] w0_init,
    input  logic [XW-1:0] w1_init,
    input  logic [XW-1:0] w2_init,
    input  logic [XW-1:0] n_init,
    input  logic          train,
    input  logic [EW-1:0] epochs,
    input  logic          start,
    input  logic          abort,
    input  logic          sync,
    input  logic          done,
    input  logic          classification,
    output logic          go,
    output logic          update,
    output logic          correct,
    output logic [XW-1:0] in_val,
    output logic          busy,
    output logic          finished,
    output logic          class_valid,
    output logic          class_out,
    output logic [CW-2:0] class_idx,
    output logic [CW-1:0] err_count,
    output logic [CW-1:0] sample_count
);

    localparam int AW = CW - 1;

    state_t        state;
    logic [AW-1:0] idx;
    logic [EW-1:0] epoch;
    logic [EW-1:0] ep_last;
    logic [XW-1:0] w0_q, w1_q, w2_q, n_q;
    logic          train_q;
    logic          wr_ok;
    sample_t       wdata;
    sample_t       rd;

    assign wr_ok = (state == IDLE) && wr_en && !clr
                && (sample_count < CW'(DEPTH));
    assign wdata = '{x1: wr_x1, x2: wr_x2, label: wr_label};

    sample_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (sample_count[AW-1:0]),
        .wdata (wdata),
        .raddr (idx),
        .rdata (rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            sample_count <= '0;
            idx          <= '0;
            epoch        <= '0;
            ep_last      <= '0;
            err_count    <= '0;
            class_valid  <= 1'b0;
            class_out    <= 1'b0;
            class_idx    <= '0;
            finished     <= 1'b0;
            w0_q         <= '0;
            w1_q         <= '0;
            w2_q         <= '0;
            n_q          <= '0;
            train_q      <= 1'b0;
        end else begin
            class_valid <= 1'b0;
            finished    <= 1'b0;
            if (state != IDLE && abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (clr) sample_count <= '0;
                        else if (wr_ok) sample_count <= sample_count + CW'(1);
                        if (start && sample_count != '0) begin
                            w0_q      <= w0_init;
                            w1_q      <= w1_init;
                            w2_q      <= w2_init;
                            n_q       <= n_init;
                            train_q   <= train;
                            ep_last   <= (epochs == '0) ? '0 : epochs - EW'(1);
                            err_count <= '0;
                            idx       <= '0;
                            epoch     <= '0;
                            state     <= LD_W0;
                        end
                    end
                    LD_W0: if (sync) state <= LD_W1;
                    LD_W1: if (sync) state <= LD_W2;
                    LD_W2: if (sync) state <= LD_N;
                    LD_N:  if (sync) state <= LD_X1;
                    LD_X1: if (sync) state <= LD_X2;
                    LD_X2: state <= WAIT_DONE;
                    WAIT_DONE: begin
                        if (done) begin
                            class_valid <= 1'b1;
                            class_out   <= classification;
                            class_idx   <= idx;
                            if (classification != rd.label && err_count != '1)
                                err_count <= err_count + CW'(1);
                            state <= NEXT;
                        end
                    end
                    NEXT: begin
                        // Later samples and epochs skip the weight preamble.
                        if (({1'b0, idx} + CW'(1)) < sample_count) begin
                            idx   <= idx + AW'(1);
                            state <= LD_X1;
                        end else if (epoch < ep_last) begin
                            idx       <= '0;
                            epoch     <= epoch + EW'(1);
                            err_count <= '0;
                            state     <= LD_X1;
                        end else begin
                            finished <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        go      = 1'b0;
        in_val  = '0;
        update  = 1'b0;
        correct = 1'b0;
        case (state)
            LD_W0: begin go = 1'b1; in_val = w0_q;  end
            LD_W1: begin go = 1'b1; in_val = w1_q;  end
            LD_W2: begin go = 1'b1; in_val = w2_q;  end
            LD_N:  begin go = 1'b1; in_val = n_q;   end
            LD_X1: begin go = 1'b1; in_val = rd.x1; end
            LD_X2: begin go = 1'b1; in_val = rd.x2; end
            default: ;
        endcase
        if (state == LD_X1 || state == LD_X2 || state == WAIT_DONE) begin
            update  = train_q;
            correct = rd.label;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_perceptron_driver.sv
// Randomised bench for perceptron_driver with a behavioural perceptron
// and a queue-based model of the expected word stream and results.
module tb_perceptron_driver;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset, wr_en, wr_label, clr, train, start, abort;
    logic          sync, done, classification, stall;
    logic [5:0]    wr_x1, wr_x2, w0_init, w1_init, w2_init, n_init;
    logic [3:0]    epochs;
    logic          go, update, correct, busy, finished;
    logic          class_valid, class_out;
    logic [5:0]    in_val;
    logic [CW-2:0] class_idx;
    logic [CW-1:0] err_count, sample_count;

    assign sync = go & ~stall;
    always #5 clk = ~clk;

    perceptron_driver #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_x1(wr_x1),
        .wr_x2(wr_x2), .wr_label(wr_label), .clr(clr),
        .w0_init(w0_init), .w1_init(w1_init), .w2_init(w2_init),
        .n_init(n_init), .train(train), .epochs(epochs),
        .start(start), .abort(abort), .sync(sync), .done(done),
        .classification(classification), .go(go), .update(update),
        .correct(correct), .in_val(in_val), .busy(busy),
        .finished(finished), .class_valid(class_valid),
        .class_out(class_out), .class_idx(class_idx),
        .err_count(err_count), .sample_count(sample_count)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // reference buffer contents
    logic [5:0] bx1 [DEPTH];
    logic [5:0] bx2 [DEPTH];
    logic       blab[DEPTH];
    int         mcount = 0;

    // perceptron model / observer state
    logic [5:0] got_words[$];
    logic       prev_go = 0, prev_sync = 0, pend = 0, last_cls = 0;
    logic       cur_train = 0;
    logic [5:0] prev_val = 0;
    int dly = 0, dly_cfg = 1, stall_mode = 0, stall_pct = 30;
    int held = 0, w1_cycles = 0, ccount = 0, fin_cnt = 0, falls = 0;
    int cls_mode = 0, m_err = 0;

    always @(negedge clk) begin
        int n, si;
        n = (mcount == 0) ? 1 : mcount;
        if (reset) begin
            prev_go = 0; prev_sync = 0; pend = 0; done = 0; stall = 0;
        end else begin
            if (go && (!prev_go || prev_sync)) got_words.push_back(in_val);
            else if (go) chk("hold", in_val, prev_val);
            if (go && got_words.size() == 2) w1_cycles++;
            stall = 0;
            if (go && stall_mode == 1)
                stall = ($urandom_range(99) < stall_pct);
            if (go && stall_mode == 2 && got_words.size() == 2 && held < 5) begin
                stall = 1; held++;
            end
            if (done) done = 0;
            if (!busy) pend = 0;
            else if (prev_go && !go) begin
                pend = 1; dly = dly_cfg; falls++;
            end
            if (pend) begin
                if (dly == 0) begin
                    pend = 0;
                    done = 1;
                    classification = cls_mode ? 1'b0 : 1'($urandom_range(1));
                    last_cls = classification;
                    chk("update", update, cur_train);
                    chk("correct", correct, blab[ccount % n]);
                end else dly--;
            end
            if (class_valid) begin
                si = ccount % n;
                if (si == 0) m_err = 0;
                if (last_cls != blab[si] && m_err < (1 << CW) - 1) m_err++;
                chk("class_idx", class_idx, si);
                chk("class_out", class_out, last_cls);
                chk("err_count", err_count, m_err);
                ccount++;
            end
            if (finished) fin_cnt++;
            prev_sync = go && !stall;
        end
        prev_go = go;
        prev_val = in_val;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [5:0] b, input logic l);
        wr_en = 1; wr_x1 = a; wr_x2 = b; wr_label = l;
        step();
        wr_en = 0;
        if (mcount < DEPTH) begin
            bx1[mcount] = a; bx2[mcount] = b; blab[mcount] = l;
            mcount++;
        end
    endtask

    task automatic clear();
        clr = 1;
        step();
        clr = 0;
        mcount = 0;
    endtask

    task automatic arm(input logic tr, input int d, input int sm);
        got_words.delete();
        ccount = 0; fin_cnt = 0; held = 0; w1_cycles = 0; falls = 0;
        m_err = 0; dly_cfg = d; stall_mode = sm; cur_train = tr;
    endtask

    task automatic run_case(input string tag, input logic tr,
                            input logic [3:0] ep, input int d, input int sm);
        logic [5:0] exp_q[$];
        int e_n, n, t;
        n = mcount;
        e_n = (ep == 0) ? 1 : int'(ep);
        w0_init = 6'($urandom); w1_init = 6'($urandom);
        w2_init = 6'($urandom); n_init = 6'($urandom);
        exp_q = {w0_init, w1_init, w2_init, n_init};
        for (int e = 0; e < e_n; e++)
            for (int i = 0; i < n; i++) begin
                exp_q.push_back(bx1[i]);
                exp_q.push_back(bx2[i]);
            end
        arm(tr, d, sm);
        train = tr; epochs = ep; start = 1;
        step();
        start = 0;
        w0_init = 6'($urandom); w1_init = 6'($urandom);
        w2_init = 6'($urandom); n_init = 6'($urandom);
        train = ~tr;
        t = 0;
        while (fin_cnt == 0 && t < 3000) begin
            step(); t++;
        end
        chk({tag, "_timeout"}, 32'(t < 3000), 1);
        repeat (3) step();
        chk({tag, "_finished"}, fin_cnt, 1);
        chk({tag, "_classes"}, ccount, n * e_n);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_nwords"}, got_words.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i),
                (i < got_words.size()) ? 32'(got_words[i]) : 32'hFFFF,
                32'(exp_q[i]));
        if (sm == 2) chk({tag, "_w1cycles"}, w1_cycles, 6);
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_go"}, go, 0);
        chk({tag, "_in_val"}, in_val, 0);
        chk({tag, "_upd"}, update, 0);
        chk({tag, "_cor"}, correct, 0);
        chk({tag, "_fin"}, finished, 0);
        chk({tag, "_cv"}, class_valid, 0);
        chk({tag, "_cout"}, class_out, 0);
        chk({tag, "_cidx"}, class_idx, 0);
        chk({tag, "_err"}, err_count, 0);
        chk({tag, "_cnt"}, sample_count, 0);
    endtask

    initial begin
        int t, k;
        reset = 1; wr_en = 0; wr_label = 0; clr = 0; train = 0;
        start = 0; abort = 0; done = 0; classification = 0; stall = 0;
        wr_x1 = 0; wr_x2 = 0; w0_init = 0; w1_init = 0; w2_init = 0;
        n_init = 0; epochs = 0;
        step(); step();
        reset = 0;
        chk_idle_outs("reset");

        start = 1;
        step();
        start = 0;
        chk("empty_start_busy", busy, 0);
        step();
        chk("empty_start_busy2", busy, 0);

        cls_mode = 0;
        wr(6'd11, 6'd22, 1'b1);
        wr(6'd33, 6'd44, 1'b0);
        chk("count2", sample_count, 2);
        run_case("basic", 1'b0, 4'd1, 1, 0);
        run_case("stall", 1'b1, 4'd1, 1, 2);

        clear();
        wr(6'd5, 6'd6, 1'b1);
        wr(6'd7, 6'd8, 1'b0);
        cls_mode = 1;
        run_case("ep2", 1'b1, 4'd2, 1, 0);
        chk("ep2_err_final", err_count, 1);

        clear();
        for (int i = 0; i < 5; i++)
            wr(6'(i * 9 + 1), 6'(i * 7 + 2), 1'(i));
        chk("full_count", sample_count, 4);
        cls_mode = 0;
        run_case("full", 1'b0, 4'd0, 0, 1);
        clr = 1; wr_en = 1; wr_x1 = 6'd63;
        step();
        clr = 0; wr_en = 0; mcount = 0;
        chk("clr_wr_count", sample_count, 0);

        wr(6'd12, 6'd13, 1'b1);
        wr(6'd14, 6'd15, 1'b0);
        cls_mode = 1;
        arm(1'b1, 6, 0);
        train = 1; epochs = 4'd1; start = 1;
        step();
        start = 0;
        t = 0;
        while (falls < 2 && t < 200) begin
            step(); t++;
        end
        chk("abort_reach", 32'(t < 200), 1);
        abort = 1;
        step();
        abort = 0;
        chk("abort_busy", busy, 0);
        chk("abort_go", go, 0);
        chk("abort_err_kept", err_count, m_err);
        repeat (8) step();
        chk("abort_fin", fin_cnt, 0);
        chk("abort_classes", ccount, 1);
        chk("abort_count", sample_count, 2);

        arm(1'b0, 1, 0);
        start = 1;
        step();
        start = 0;
        repeat (6) step();
        chk("midrun_busy", busy, 1);
        reset = 1;
        step();
        reset = 0;
        mcount = 0;
        chk_idle_outs("midreset");

        cls_mode = 0;
        stall_pct = 30;
        for (int r = 0; r < 6; r++) begin
            clear();
            k = $urandom_range(DEPTH, 1);
            for (int i = 0; i < k; i++)
                wr(6'($urandom), 6'($urandom), 1'($urandom_range(1)));
            run_case($sformatf("rnd%0d", r), 1'($urandom_range(1)),
                     4'($urandom_range(3)), $urandom_range(3), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
